mold_udp64_header_encoder: RTL and testbench
============================================

// Module: mold_udp64_header_encoder
// PURPOSE
//  Transmit-side MoldUDP64 header generator: serialises SessionID, SequenceNumber and MessageCount
//  into 64-bit datapath beats 5..7 of the egress frame, bit-aligned with the receive-side decoder.
//  Owns the downstream sequence counter (auto-advance by MessageCount per packet).
//  Sits between the packet scheduler (start/count) and the Ethernet/IP/UDP framer that muxes beats.
// PARAMETERS
//  FIRST_BEAT   5       beat index of first header word (header occupies FIRST_BEAT..FIRST_BEAT+2)
//  SEQ_INIT     64'd1   sequence number after reset
//  HB_INTERVAL  1000    idle cycles before auto-heartbeat (used only with MOLD_HEARTBEAT_EN)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  sessionIdIn  in   80  session ID, sampled at start accept
//  msgCountIn   in   16  message count for packet, sampled at start accept
//  start        in   1   request one header; accepted when start && startReady
//  startReady   out  1   high only in IDLE with no seqLoad this cycle
//  seqLoad      in   1   load next sequence number (IDLE or ENDED only; ignored elsewhere)
//  seqLoadValue in   64  value loaded by seqLoad
//  dataOut      out  64  header beat data
//  beatIndex    out  3   frame beat index of dataOut (FIRST_BEAT..FIRST_BEAT+2), 0 when !outValid
//  outValid     out  1   dataOut/beatIndex valid
//  outReady     in   1   downstream accepts beat when outValid && outReady
//  done         out  1   1-cycle pulse the cycle after last beat accepted
//  nextSeq      out  64  sequence number the next packet will carry
//  sessionEnded out  1   high in ENDED state
// BEHAVIOUR
//  Reset (async): state IDLE; dataOut=0, beatIndex=0, outValid=0, done=0, sessionEnded=0, nextSeq=SEQ_INIT.
//  FSM: IDLE -start accept-> B0 -beat accept-> B1 -> B2 -> (IDLE | ENDED); ENDED -seqLoad-> IDLE.
//  On start accept: snapshot sid=sessionIdIn, cnt=msgCountIn, seq=nextSeq; outValid high next cycle.
//  Beat layout (must match decoder exactly):
//   B0: dataOut[63:32]=sid[31:0], dataOut[31:0]=0 (lower half owned by framer, OR-merged)
//   B1: dataOut[47:0]=sid[79:32], dataOut[63:48]=seq[15:0]
//   B2: dataOut[47:0]=seq[63:16], dataOut[63:48]=cnt
//  Handshake: advance only on outValid&&outReady; dataOut/beatIndex held stable while stalled.
//  Back-to-back: beats issue on consecutive cycles with outReady=1; min packet period 4 cycles (1 idle).
//  Sequence update on B2 accept: cnt in 1..0xFFFE -> nextSeq += cnt, mod 2^64 (wrap to 0 allowed);
//   cnt=0 (heartbeat) -> unchanged; cnt=0xFFFF (end-of-session) -> unchanged, enter ENDED.
//  ENDED: startReady=0, start ignored; only seqLoad or rst exits.
//  seqLoad and start same cycle in IDLE: seqLoad wins, startReady=0, start not accepted.
//  seqLoad during B0..B2: ignored; in-flight packet uses snapshot seq.
//  Input changes after accept do not affect in-flight beats.
//  rst mid-packet: beats abort immediately, no done pulse, nextSeq=SEQ_INIT.
// CONFIGURATION
//  MOLD_HEARTBEAT_EN defined: idle counter counts cycles in IDLE with no start accept; at HB_INTERVAL
//   it self-issues a heartbeat (cnt=0, sid=sessionIdIn) with startReady forced 0 that cycle; counter
//   clears on any packet start (external or auto) and on seqLoad. Not active in ENDED.
//  MOLD_HEARTBEAT_EN undefined: no counter, no auto packets; HB_INTERVAL unused.
// TESTING
//  1. sid=80'h0123456789ABCDEF0011, cnt=3, nextSeq=1, outReady=1 -> B0=64'h89ABCDEF_00000000? no:
//     B0[63:32]=32'hCDEF0011, B1={16'h0001,48'h0123456789AB}, B2={16'h0003,48'h0}; nextSeq=4, done pulse.
//  2. Same packet, outReady low 5 cycles on B1 -> B1 held stable, beatIndex=6 throughout, total 8 cycles.
//  3. seqLoad 64'hFFFF_FFFF_FFFF_FFFE then cnt=5 -> B1[63:48]=16'hFFFE, nextSeq wraps to 64'd3.
//  4. cnt=0 heartbeat -> B2[63:48]=0, nextSeq unchanged; cnt=0xFFFF -> sessionEnded=1, next start ignored.
//  5. rst asserted during B1 -> outValid=0 same cycle (async), nextSeq=1, no done pulse.
//  6. MOLD_HEARTBEAT_EN, HB_INTERVAL=8, idle -> heartbeat beats begin 9 cycles after reset release; none
//     without macro.

Source files
------------

// File: rtl/mold_udp64_header_encoder_if.sv
// Header-encoder bus: scheduler request side, sequence load and the beat stream to the framer.
interface mold_udp64_header_encoder_if;
    localparam int unsigned SID_W  = 80;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SEQ_W  = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BEAT_W = 3;

    logic [SID_W-1:0]  sessionIdIn;
    logic [CNT_W-1:0]  msgCountIn;
    logic              start;
    logic              startReady;
    logic              seqLoad;
    logic [SEQ_W-1:0]  seqLoadValue;
    logic [DATA_W-1:0] dataOut;
    logic [BEAT_W-1:0] beatIndex;
    logic              outValid;
    logic              outReady;
    logic              done;
    logic [SEQ_W-1:0]  nextSeq;
    logic              sessionEnded;

    modport master (
        output sessionIdIn, msgCountIn, start, seqLoad, seqLoadValue, outReady,
        input  startReady, dataOut, beatIndex, outValid, done, nextSeq, sessionEnded
    );

    modport slave (
        input  sessionIdIn, msgCountIn, start, seqLoad, seqLoadValue, outReady,
        output startReady, dataOut, beatIndex, outValid, done, nextSeq, sessionEnded
    );
endinterface

// File: rtl/mold_udp64_header_encoder.sv
// MoldUDP64 header beat generator with owned downstream sequence counter.
// Optional MOLD_HEARTBEAT_EN: self-issued heartbeat after HB_INTERVAL idle cycles.
module mold_udp64_header_encoder #(
    parameter int unsigned FIRST_BEAT = 5,
    parameter logic [63:0] SEQ_INIT   = 64'd1
`ifdef MOLD_HEARTBEAT_EN
    , parameter int unsigned HB_INTERVAL = 1000
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    mold_udp64_header_encoder_if.slave  bus
);
    localparam int unsigned SID_W  = 80;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SEQ_W  = 64;
    localparam int unsigned BEAT_W = 3;
    localparam logic [CNT_W-1:0] CNT_END = 16'hFFFF;

    typedef enum logic [2:0] {ST_IDLE, ST_B0, ST_B1, ST_B2, ST_ENDED} state_t;

    state_t             state;
    logic [SID_W-1:32]  sid_hi;
    logic [CNT_W-1:0]   cnt;
    logic [SEQ_W-1:0]   seq;
    logic               auto_start;
    logic               launch;
    logic               beat_acc;
    logic [CNT_W-1:0]   launch_cnt;

`ifdef MOLD_HEARTBEAT_EN
    localparam int unsigned HB_W = 32;
    logic [HB_W-1:0] idle_cnt;

    assign auto_start = (state == ST_IDLE) && !bus.seqLoad &&
                        (idle_cnt == HB_W'(HB_INTERVAL - 1));

    // Idle-time counter; any packet start or sequence load restarts the interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (state != ST_IDLE || launch || bus.seqLoad)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + HB_W'(1);
    end
`else
    assign auto_start = 1'b0;
`endif

    assign bus.startReady = (state == ST_IDLE) && !bus.seqLoad && !auto_start;
    assign launch         = (bus.start && bus.startReady) || auto_start;
    assign launch_cnt     = auto_start ? '0 : bus.msgCountIn;
    assign beat_acc       = bus.outValid && bus.outReady;

    // Header FSM; B0 data is formed from the live inputs at accept so it is ready next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            sid_hi           <= '0;
            cnt              <= '0;
            seq              <= '0;
            bus.dataOut      <= '0;
            bus.beatIndex    <= '0;
            bus.outValid     <= 1'b0;
            bus.done         <= 1'b0;
            bus.sessionEnded <= 1'b0;
            bus.nextSeq      <= SEQ_INIT;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.seqLoad) begin
                        bus.nextSeq <= bus.seqLoadValue;
                    end else if (launch) begin
                        sid_hi        <= bus.sessionIdIn[SID_W-1:32];
                        cnt           <= launch_cnt;
                        seq           <= bus.nextSeq;
                        bus.dataOut   <= {bus.sessionIdIn[31:0], 32'h0};
                        bus.beatIndex <= BEAT_W'(FIRST_BEAT);
                        bus.outValid  <= 1'b1;
                        state         <= ST_B0;
                    end
                end
                ST_B0: begin
                    if (beat_acc) begin
                        bus.dataOut   <= {seq[15:0], sid_hi};
                        bus.beatIndex <= BEAT_W'(FIRST_BEAT + 1);
                        state         <= ST_B1;
                    end
                end
                ST_B1: begin
                    if (beat_acc) begin
                        bus.dataOut   <= {cnt, seq[SEQ_W-1:16]};
                        bus.beatIndex <= BEAT_W'(FIRST_BEAT + 2);
                        state         <= ST_B2;
                    end
                end
                ST_B2: begin
                    if (beat_acc) begin
                        bus.dataOut   <= '0;
                        bus.beatIndex <= '0;
                        bus.outValid  <= 1'b0;
                        bus.done      <= 1'b1;
                        if (cnt == CNT_END) begin
                            bus.sessionEnded <= 1'b1;
                            state            <= ST_ENDED;
                        end else begin
                            // Heartbeat (cnt=0) leaves the sequence where it is
                            bus.nextSeq <= bus.nextSeq + SEQ_W'(cnt);
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_ENDED: begin
                    if (bus.seqLoad) begin
                        bus.nextSeq      <= bus.seqLoadValue;
                        bus.sessionEnded <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mold_udp64_header_encoder.sv
// Self-checking bench for mold_udp64_header_encoder: vector table plus beat scoreboard.
module tb_mold_udp64_header_encoder;
    logic clk = 1'b0;
    logic rst;

    mold_udp64_header_encoder_if bus();

    mold_udp64_header_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          load;
        logic [63:0] load_val;
        logic [79:0] sid;
        logic [15:0] cnt;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] b2;
        logic [63:0] exp_next;
        bit          exp_ended;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  idx;
    } beat_t;

    vec_t  vecs[6];
    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    done_seen = 0;
    int    valid_cycles = 0;
    bit    exp_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beats(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2);
        sb.push_back('{data: b0, idx: 3'd5});
        sb.push_back('{data: b1, idx: 3'd6});
        sb.push_back('{data: b2, idx: 3'd7});
    endtask

    // Scoreboard monitor: compares every accepted beat and the done pulse timing
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            exp_done = 0;
        end else begin
            if (bus.done || exp_done) check("done_pulse", 64'(bus.done), 64'(exp_done));
            if (bus.done) done_seen++;
            exp_done = 0;
            if (bus.outValid) valid_cycles++;
            else check("idle_beat_index", 64'(bus.beatIndex), 64'd0);
            if (bus.outValid && bus.outReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(bus.beatIndex), 64'd0);
                end else begin
                    b = sb.pop_front();
                    check("beat_data", bus.dataOut, b.data);
                    check("beat_index", 64'(bus.beatIndex), 64'(b.idx));
                    exp_done = (b.idx == 3'd7);
                end
            end
        end
    end

    task automatic wait_done(input int d0);
        for (int i = 0; i < 40 && done_seen == d0; i++) @(posedge clk);
        check("done_seen", 64'(done_seen != d0), 64'd1);
        #1;
    endtask

    task automatic send_pkt(input vec_t v);
        int d0;
        @(negedge clk);
        for (int i = 0; i < 20 && !bus.startReady; i++) @(negedge clk);
        check("start_ready", 64'(bus.startReady), 64'd1);
        bus.sessionIdIn = v.sid;
        bus.msgCountIn  = v.cnt;
        bus.start       = 1'b1;
        push_beats(v.b0, v.b1, v.b2);
        d0 = done_seen;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.sessionIdIn = {$urandom, $urandom, 16'($urandom)};
        bus.msgCountIn  = 16'($urandom);
        wait_done(d0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int vc;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.seqLoad = 1'b0;
        bus.seqLoadValue = '0;
        bus.sessionIdIn = '0;
        bus.msgCountIn = '0;
        bus.outReady = 1'b1;

        vecs[0] = '{0, 64'h0, 80'h0123456789ABCDEF0011, 16'd3,
                    64'hCDEF0011_00000000, 64'h0001_0123456789AB, 64'h0003_000000000000,
                    64'd4, 0};
        vecs[1] = '{0, 64'h0, 80'hFFFF_0000_1111_2222_3333, 16'h0100,
                    64'h22223333_00000000, 64'h0004_FFFF00001111, 64'h0100_000000000000,
                    64'h104, 0};
        vecs[2] = '{0, 64'h0, 80'hA5A5_5A5A_C3C3_3C3C_0F0F, 16'h0000,
                    64'h3C3C0F0F_00000000, 64'h0104_A5A55A5AC3C3, 64'h0,
                    64'h104, 0};
        vecs[3] = '{1, 64'hFFFF_FFFF_FFFF_FFFE, 80'h0, 16'd5,
                    64'h0, 64'hFFFE_000000000000, 64'h0005_FFFFFFFFFFFF,
                    64'd3, 0};
        vecs[4] = '{1, 64'h0123_4567_89AB_CDEF, 80'h1, 16'hFFFE,
                    64'h00000001_00000000, 64'hCDEF_000000000000, 64'hFFFE_0123456789AB,
                    64'h0123_4567_89AC_CDED, 0};
        vecs[5] = '{0, 64'h0, 80'h0, 16'hFFFF,
                    64'h0, 64'hCDED_000000000000, 64'hFFFF_0123456789AC,
                    64'h0123_4567_89AC_CDED, 1};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.outValid), 64'd0);
        check("rst_data", bus.dataOut, 64'd0);
        check("rst_beat_index", 64'(bus.beatIndex), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_ended", 64'(bus.sessionEnded), 64'd0);
        check("rst_next_seq", bus.nextSeq, 64'd1);
        rst = 1'b0;

`ifndef MOLD_HEARTBEAT_EN
        repeat (20) @(negedge clk);
        check("no_auto_packet", 64'(valid_cycles), 64'd0);
`endif

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].load) begin
                // seqLoad and start together: load wins, nothing launches
                @(negedge clk);
                bus.seqLoad = 1'b1;
                bus.seqLoadValue = vecs[i].load_val;
                bus.start = 1'b1;
                #1;
                check("load_blocks_start", 64'(bus.startReady), 64'd0);
                @(posedge clk);
                #1;
                bus.seqLoad = 1'b0;
                bus.start = 1'b0;
                check("load_no_launch", 64'(bus.outValid), 64'd0);
                check("load_value", bus.nextSeq, vecs[i].load_val);
            end
            send_pkt(vecs[i]);
            check("vec_next_seq", bus.nextSeq, vecs[i].exp_next);
            check("vec_ended", 64'(bus.sessionEnded), 64'(vecs[i].exp_ended));
        end

        // ENDED: start ignored until seqLoad
        vc = valid_cycles;
        @(negedge clk);
        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ended_start_ready", 64'(bus.startReady), 64'd0);
        end
        bus.start = 1'b0;
        check("ended_no_beats", 64'(valid_cycles - vc), 64'd0);
        bus.seqLoad = 1'b1;
        bus.seqLoadValue = 64'd1;
        @(posedge clk);
        #1;
        bus.seqLoad = 1'b0;
        check("ended_exit", 64'(bus.sessionEnded), 64'd0);
        check("ended_reload", bus.nextSeq, 64'd1);

        // Stall on B1 for 5 cycles with a seqLoad that must be ignored
        @(negedge clk);
        bus.sessionIdIn = vecs[0].sid;
        bus.msgCountIn = vecs[0].cnt;
        bus.start = 1'b1;
        push_beats(vecs[0].b0, vecs[0].b1, vecs[0].b2);
        d0 = done_seen;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.sessionIdIn = '1;
        bus.msgCountIn = 16'h1234;
        vc = valid_cycles;
        @(posedge clk);
        #1;
        bus.outReady = 1'b0;
        bus.seqLoad = 1'b1;
        bus.seqLoadValue = 64'hDEAD;
        repeat (5) begin
            @(negedge clk);
            check("stall_data", bus.dataOut, vecs[0].b1);
            check("stall_index", 64'(bus.beatIndex), 64'd6);
        end
        @(posedge clk);
        #1;
        bus.outReady = 1'b1;
        bus.seqLoad = 1'b0;
        wait_done(d0);
        check("stall_valid_cycles", 64'(valid_cycles - vc), 64'd8);
        check("stall_next_seq", bus.nextSeq, 64'd4);

        // Asynchronous reset while B1 is on the bus
        @(negedge clk);
        bus.sessionIdIn = vecs[0].sid;
        bus.msgCountIn = 16'd3;
        bus.start = 1'b1;
        push_beats(64'hCDEF0011_00000000, 64'h0004_0123456789AB, 64'h0003_000000000000);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.beatIndex == 3'd6) break;
        end
        check("mid_reached_b1", 64'(bus.beatIndex), 64'd6);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.outValid), 64'd0);
        check("mid_rst_index", 64'(bus.beatIndex), 64'd0);
        check("mid_rst_next_seq", bus.nextSeq, 64'd1);
        sb.delete();
        d0 = done_seen;
        vc = valid_cycles;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_done", 64'(done_seen - d0), 64'd0);
        check("mid_rst_no_beats", 64'(valid_cycles - vc), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
